// File: rtl/mac_selfcheck_seq.sv
// On-chip stimulus sequencer and result checker for a MAC block (out = a*b + c).
// Walks a directed table or an exhaustive sweep and accumulates pass/fail status.
module mac_selfcheck_seq #(
    parameter int DATA_WIDTH  = 4,
    parameter int OUT_WIDTH   = 8,
    parameter int MAC_LATENCY = 1,
    parameter int ERR_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    output logic [DATA_WIDTH-1:0]   a,
    output logic [DATA_WIDTH-1:0]   b,
    output logic [DATA_WIDTH-1:0]   c,
    input  logic [OUT_WIDTH-1:0]    mac_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_WIDTH-1:0]    err_count,
    output logic [3*DATA_WIDTH-1:0] fail_idx,
    output logic [3*DATA_WIDTH-1:0] vec_idx
);

    localparam int VW = 3 * DATA_WIDTH;
    localparam int SW = 2 * DATA_WIDTH;
    localparam int CW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    localparam logic [VW-1:0]        VEC_ONE  = 1;
    localparam logic [ERR_WIDTH-1:0] ERR_ONE  = 1;
    localparam logic [CW-1:0]        CNT_ONE  = 1;
    localparam logic [CW-1:0]        CNT_LOAD = CW'(MAC_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

    state_t                 state;
    logic                   mode_q;
    logic                   first_fail;
    logic [CW-1:0]          wait_cnt;
    logic [OUT_WIDTH-1:0]   expected;
    logic [DATA_WIDTH-1:0]  va, vb, vc;
    logic [SW-1:0]          prod_sum;
    logic [VW-1:0]          last_idx;
    logic                   mismatch;

    // Operand source for the current vec_idx: table lookup or a straight bit split
    always_comb begin
        va = vec_idx[VW-1:SW];
        vb = vec_idx[SW-1:DATA_WIDTH];
        vc = vec_idx[DATA_WIDTH-1:0];
        if (!mode_q) begin
            case (vec_idx[1:0])
                2'd0: begin va = DATA_WIDTH'(3);  vb = DATA_WIDTH'(5);  vc = DATA_WIDTH'(7);  end
                2'd1: begin va = DATA_WIDTH'(9);  vb = DATA_WIDTH'(7);  vc = DATA_WIDTH'(4);  end
                2'd2: begin va = DATA_WIDTH'(13); vb = DATA_WIDTH'(9);  vc = DATA_WIDTH'(5);  end
                default: begin va = DATA_WIDTH'(15); vb = DATA_WIDTH'(15); vc = DATA_WIDTH'(15); end
            endcase
        end
    end

    // a*b + c never exceeds 2*DATA_WIDTH bits, so the sum is exact before resizing
    assign prod_sum = SW'(va) * SW'(vb) + SW'(vc);
    assign last_idx = mode_q ? {VW{1'b1}} : VW'(3);
    assign mismatch = (mac_out != expected);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            first_fail <= 1'b0;
            wait_cnt   <= '0;
            expected   <= '0;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_idx   <= '0;
            vec_idx    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q     <= mode;
                        err_count  <= '0;
                        fail_idx   <= '0;
                        first_fail <= 1'b0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        vec_idx    <= '0;
                        busy       <= 1'b1;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    a        <= va;
                    b        <= vb;
                    c        <= vc;
                    expected <= OUT_WIDTH'(prod_sum);
                    wait_cnt <= CNT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_ONE;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != {ERR_WIDTH{1'b1}}) begin
                            err_count <= err_count + ERR_ONE;
                        end
                        if (!first_fail) begin
                            fail_idx   <= vec_idx;
                            first_fail <= 1'b1;
                        end
                    end
                    // pass must include this final comparison, not just the registered count
                    if (vec_idx == last_idx) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                        state <= DONE;
                    end else begin
                        vec_idx <= vec_idx + VEC_ONE;
                        state   <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_selfcheck_seq.sv
// Bench for mac_selfcheck_seq: two instances (MAC latency 1 and 3) with behavioural MACs,
// operand and result scoreboards filled when each run is started.
module tb_mac_selfcheck_seq;

    typedef struct {
        logic [3:0]  a, b, c;
        logic [11:0] idx;
    } op_t;

    typedef struct {
        logic [15:0] err;
        logic [11:0] fidx;
        logic        pass;
        logic [3:0]  a, b, c;
        logic [11:0] vidx;
    } result_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        mode0 = 1'b0, mode1 = 1'b0;
    logic        stuck0 = 1'b0;
    logic [3:0]  a0, b0, c0, a1, b1, c1;
    logic [7:0]  mac_out0, mac_out1, m0;
    logic [7:0]  p1 [3];
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] err0, err1;
    logic [11:0] fidx0, fidx1, vidx0, vidx1;
    logic [11:0] last_abc = '0;

    int checks = 0;
    int errors = 0;
    int cyc;
    op_t     op_q[$];
    result_t res_q0[$];
    result_t res_q1[$];

    int ta[4] = '{3, 9, 13, 15};
    int tbv[4] = '{5, 7, 9, 15};
    int tc[4] = '{7, 4, 5, 15};

    always #5 clk = ~clk;

    mac_selfcheck_seq #(.DATA_WIDTH(4), .OUT_WIDTH(8), .MAC_LATENCY(1), .ERR_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .mode(mode0),
        .a(a0), .b(b0), .c(c0), .mac_out(mac_out0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_idx(fidx0), .vec_idx(vidx0)
    );

    mac_selfcheck_seq #(.DATA_WIDTH(4), .OUT_WIDTH(8), .MAC_LATENCY(3), .ERR_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode1),
        .a(a1), .b(b1), .c(c1), .mac_out(mac_out1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_idx(fidx1), .vec_idx(vidx1)
    );

    // Behavioural MACs; stuck0 forces bit 0 of the first one low
    always @(posedge clk) begin
        m0 <= 8'(a0) * 8'(b0) + 8'(c0);
        p1[0] <= 8'(a1) * 8'(b1) + 8'(c1);
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign mac_out0 = stuck0 ? {m0[7:1], 1'b0} : m0;
    assign mac_out1 = p1[2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Each new operand triple seen on DUT0 while busy is matched against the queued vector
    always @(negedge clk) begin
        if (!reset) begin
            last_abc = '0;
        end else if (busy0 && {a0, b0, c0} != last_abc) begin
            last_abc = {a0, b0, c0};
            if (op_q.size() == 0) begin
                check_val("op_unexpected", {20'd0, a0, b0, c0}, 32'hFFFF_FFFF);
            end else begin
                op_t e;
                e = op_q.pop_front();
                check_val("op_a", a0, e.a);
                check_val("op_b", b0, e.b);
                check_val("op_c", c0, e.c);
                check_val("op_idx", vidx0, e.idx);
            end
        end
    end

    task automatic pulse_start(input int sel, input logic m);
        @(negedge clk);
        if (sel == 0) begin start0 = 1'b1; mode0 = m; end
        else begin start1 = 1'b1; mode1 = m; end
        @(posedge clk);
        #1;
        start0 = 1'b0; start1 = 1'b0; mode0 = 1'b0; mode1 = 1'b0;
    endtask

    task automatic apply_stimulus(input int sel, input logic m, input logic fault);
        result_t r;
        int exp_v, obs_v, nerr;
        nerr = 0;
        r.fidx = '0;
        stuck0 = fault;
        if (!m) begin
            for (int i = 0; i < 4; i++) begin
                exp_v = (ta[i] * tbv[i] + tc[i]) % 256;
                obs_v = fault ? (exp_v & 254) : exp_v;
                if (sel == 0) op_q.push_back('{4'(ta[i]), 4'(tbv[i]), 4'(tc[i]), 12'(i)});
                if (obs_v != exp_v) begin
                    if (nerr == 0) r.fidx = 12'(i);
                    nerr++;
                end
            end
            r.vidx = 12'd3;
        end else begin
            for (int i = 0; i < 4096; i++) begin
                if (sel == 0) op_q.push_back('{4'(i >> 8), 4'((i >> 4) & 15), 4'(i & 15), 12'(i)});
            end
            r.vidx = 12'hFFF;
        end
        r.err = 16'(nerr);
        r.pass = (nerr == 0);
        r.a = 4'd15; r.b = 4'd15; r.c = 4'd15;
        if (sel == 0) res_q0.push_back(r); else res_q1.push_back(r);
        pulse_start(sel, m);
        check_val("busy_after_start", (sel == 0) ? busy0 : busy1, 1);
        check_val("done_after_start", (sel == 0) ? done0 : done1, 0);
    endtask

    task automatic wait_done(input int sel, input int budget, output int cycles);
        cycles = 0;
        while (!((sel == 0) ? done0 : done1) && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic check_output(input int sel);
        result_t e;
        if ((sel == 0 ? res_q0.size() : res_q1.size()) == 0) begin
            check_val("result_queue_empty", 0, 1);
            return;
        end
        e = (sel == 0) ? res_q0.pop_front() : res_q1.pop_front();
        if (sel == 0) begin
            check_val("done", done0, 1);
            check_val("busy", busy0, 0);
            check_val("pass", pass0, e.pass);
            check_val("err_count", err0, e.err);
            check_val("fail_idx", fidx0, e.fidx);
            check_val("vec_idx", vidx0, e.vidx);
            check_val("final_abc", {a0, b0, c0}, {e.a, e.b, e.c});
        end else begin
            check_val("l3_done", done1, 1);
            check_val("l3_pass", pass1, e.pass);
            check_val("l3_err_count", err1, e.err);
            check_val("l3_vec_idx", vidx1, e.vidx);
            check_val("l3_final_abc", {a1, b1, c1}, {e.a, e.b, e.c});
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_abc"}, {a0, b0, c0}, 0);
        check_val({tag, "_busy"}, busy0, 0);
        check_val({tag, "_done"}, done0, 0);
        check_val({tag, "_pass"}, pass0, 0);
        check_val({tag, "_err"}, err0, 0);
        check_val({tag, "_fidx"}, fidx0, 0);
        check_val({tag, "_vidx"}, vidx0, 0);
    endtask

    task automatic wait_vec(input logic [11:0] idx);
        int n;
        n = 0;
        while (vidx0 != idx && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_vec_idx", vidx0, idx);
    endtask

    initial begin
        $display("[TB] starting");
        #2 reset = 1'b0;
        #10 check_reset_state("reset");
        @(negedge clk) reset = 1'b1;

        // Directed table, correct MAC, with run-length check
        apply_stimulus(0, 1'b0, 1'b0);
        wait_done(0, 100, cyc);
        check_val("mode0_cycles", cyc, 12);
        check_output(0);

        // Bit 0 stuck low: only 67 (vector 1) is odd among the table results
        apply_stimulus(0, 1'b0, 1'b1);
        wait_done(0, 100, cyc);
        check_output(0);

        // Restart after a failing run clears the status
        apply_stimulus(0, 1'b0, 1'b0);
        check_val("restart_err", err0, 0);
        check_val("restart_fidx", fidx0, 0);
        wait_done(0, 100, cyc);
        check_output(0);

        // A start (with mode=1) while busy must be ignored
        apply_stimulus(0, 1'b0, 1'b0);
        wait_vec(12'd1);
        pulse_start(0, 1'b1);
        wait_done(0, 100, cyc);
        check_output(0);

        // Asynchronous reset mid-run, then a clean run
        apply_stimulus(0, 1'b0, 1'b0);
        wait_vec(12'd2);
        reset = 1'b0;
        #1 check_reset_state("midrun_reset");
        op_q.delete();
        res_q0.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        apply_stimulus(0, 1'b0, 1'b0);
        wait_done(0, 100, cyc);
        check_output(0);

        // Exhaustive sweep
        apply_stimulus(0, 1'b1, 1'b0);
        wait_done(0, 13000, cyc);
        check_val("sweep_cycles", cyc, 4096 * 3);
        check_output(0);
        check_val("op_queue_drained", op_q.size(), 0);

        // Latency-3 instance: five cycles per vector
        apply_stimulus(1, 1'b0, 1'b0);
        wait_done(1, 200, cyc);
        check_val("l3_cycles", cyc, 20);
        check_output(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_selfcheck_seq.md
Name: mac_selfcheck_seq

Overview:
- Hardware stimulus sequencer and result checker for the `mac` block (out = a*b + c).
- Drives operand triples into a MAC, waits the MAC's latency, samples its output and compares it against an internally computed expected value.
- Accumulates pass/fail status on chip, so board bring-up no longer depends on manual VIO poking.
- Sits beside the MAC DUT: its operand outputs feed the MAC inputs, and the MAC output returns to it.

Parameters:
- DATA_WIDTH, 4, width of operands a, b, c.
- OUT_WIDTH, 8, width of MAC result and of expected value.
- MAC_LATENCY, 1, clock cycles from an operand change to a valid MAC output (must be ≥1).
- ERR_WIDTH, 16, width of the error counter.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle pulse; begins a run when idle or done.
- mode  input  1  0 = directed table (4 vectors); 1 = exhaustive sweep (2^(3*DATA_WIDTH) vectors). Sampled on the accepted start.
- a  output  DATA_WIDTH  operand to MAC, registered.
- b  output  DATA_WIDTH  operand to MAC, registered.
- c  output  DATA_WIDTH  operand to MAC, registered.
- mac_out  input  OUT_WIDTH  result returned from MAC.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  ERR_WIDTH  number of mismatches in the current run; saturates at all-ones.
- fail_idx  output  3*DATA_WIDTH  index of the first mismatching vector; 0 if none.
- vec_idx  output  3*DATA_WIDTH  index of the vector currently applied.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - a, b, c, busy, done, pass, err_count, fail_idx and vec_idx are all cleared to 0.
  - The internal first-fail flag is cleared.
  - Reset during a run aborts it immediately; no partial status is retained.
- States: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE or DONE, with start=1:
  - Latch mode.
  - Clear err_count, fail_idx, the first-fail flag and done.
  - Set vec_idx=0 and busy=1.
  - Go to DRIVE.
- start while busy is ignored.
- DRIVE (1 cycle):
  - a, b, c are loaded from vector vec_idx on the edge that enters DRIVE's successor.
  - Expected value is registered alongside them.
  - Go to WAIT.
- WAIT: lasts MAC_LATENCY cycles (down-counter), then go to CHECK.
- CHECK (1 cycle): compare mac_out with expected.
  - On mismatch: err_count increments (saturating).
  - On the first mismatch of the run: fail_idx = vec_idx and the first-fail flag is set.
  - If vec_idx == last index, go to DONE. Otherwise vec_idx increments and go to DRIVE.
- DONE:
  - busy=0, done=1, pass = (err_count==0).
  - a, b, c hold their last values.
- Per-vector period is MAC_LATENCY+2 cycles. A run takes N*(MAC_LATENCY+2) cycles from start to done, ±1 for the entry edge.
- Directed table (mode 0), vec_idx 0..3:
  - (3,5,7) → 22 (0x16)
  - (9,7,4) → 67 (0x43)
  - (13,9,5) → 122 (0x7A)
  - (15,15,15) → 240 (0xF0)
  - For DATA_WIDTH ≠ 4, table entries are zero-extended/truncated to DATA_WIDTH.
- Exhaustive sweep (mode 1):
  - a = vec_idx[3W-1:2W], b = vec_idx[2W-1:W], c = vec_idx[W-1:0].
  - Last index is all-ones. vec_idx must not wrap past it.
- Expected arithmetic:
  - Unsigned a*b computed at 2*DATA_WIDTH bits, plus zero-extended c.
  - Result truncated (mod 2^OUT_WIDTH) to OUT_WIDTH.
  - With defaults, the maximum of 240 fits without truncation.
- Simultaneous events:
  - start in the same cycle as the CHECK→DONE transition is ignored. done must be observed first.
  - The error-counter saturation check takes priority over increment.

Test Plan:
- Mode 0, correct MAC (L=1), start pulse:
  - a/b/c step through the 4 table vectors.
  - done=1 and busy=0 after about 12 cycles.
  - pass=1, err_count=0, fail_idx=0.
- Mode 0, MAC model with out[0] stuck at 0:
  - Vectors 1 (67) and 2 (122) behave as follows: 67 mismatches, 122 is even so it matches.
  - err_count=1, fail_idx=1, pass=0.
- Mode 1, correct MAC:
  - 4096 vectors; final a=b=c=15.
  - done after about 4096*3 cycles, pass=1.
  - A golden model cross-checks the vec_idx→operand mapping.
- Reset mid-run:
  - Assert reset=0 at vec_idx=2 in mode 0.
  - All outputs go to 0 asynchronously; state is IDLE.
  - A new start gives a clean pass run.
- Start while busy at vec_idx=1: ignored; the run completes normally with vec_idx ending at 3.
- Restart after a failing run:
  - Err_count, fail_idx and done are cleared on the new start.
  - With a correct MAC, pass=1.
- Repeat with MAC_LATENCY=3: per-vector period is 5 cycles; no mismatches.
